// File: rtl/counter_pwm_compare.sv
// PWM compare stage fed by the 8-bit loadable counter: double-buffered duty, wrap-synchronous update.
// Optional complementary output with dead-time insertion when PWM_DEADTIME_EN is defined.
module counter_pwm_compare #(
    parameter int WIDTH  = 8,
    parameter int DEAD_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              count_valid,
    input  logic [WIDTH-1:0]  duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              pwm_n_out,
    input  logic [DEAD_W-1:0] dead_time,
    output logic              match_pulse,
    output logic              wrap_pulse,
    output logic [7:0]        period_cnt
);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] prev_count_q, prev_count_d;
    logic             have_prev_q, have_prev_d;
    logic             pending_q, pending_d;
    logic             pwm_raw_q, pwm_raw_d;
    logic             match_q, match_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       period_q, period_d;

    logic             wrap;
    logic             promote;
    logic             accept;
    logic [WIDTH-1:0] eff_duty;

    always_comb begin
        // Any backwards step is a wrap, including a load to a lower value.
        wrap     = count_valid && have_prev_q && (count_in < prev_count_q);
        promote  = wrap && pending_q;
        accept   = duty_valid && !pending_q;
        eff_duty = promote ? shadow_q : active_q;

        shadow_d     = shadow_q;
        active_d     = active_q;
        prev_count_d = prev_count_q;
        have_prev_d  = have_prev_q;
        pending_d    = pending_q;
        pwm_raw_d    = pwm_raw_q;
        match_d      = 1'b0;
        wrap_d       = 1'b0;
        period_d     = period_q;

        if (count_valid) begin
            prev_count_d = count_in;
            have_prev_d  = 1'b1;
            pwm_raw_d    = (count_in < eff_duty);
            match_d      = (count_in == eff_duty);
            wrap_d       = wrap;
            if (wrap) begin
                period_d = period_q + 8'd1;
            end
        end

        // Promotion needs pending=1 and accept needs pending=0, so they never collide;
        // a value accepted on a wrap cycle waits for the next wrap.
        if (promote) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = duty_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q     <= '0;
            active_q     <= '0;
            prev_count_q <= '0;
            have_prev_q  <= 1'b0;
            pending_q    <= 1'b0;
            pwm_raw_q    <= 1'b0;
            match_q      <= 1'b0;
            wrap_q       <= 1'b0;
            period_q     <= 8'd0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            prev_count_q <= prev_count_d;
            have_prev_q  <= have_prev_d;
            pending_q    <= pending_d;
            pwm_raw_q    <= pwm_raw_d;
            match_q      <= match_d;
            wrap_q       <= wrap_d;
            period_q     <= period_d;
        end
    end

    assign duty_ready  = !pending_q;
    assign match_pulse = match_q;
    assign wrap_pulse  = wrap_q;
    assign period_cnt  = period_q;

`ifdef PWM_DEADTIME_EN
    localparam logic [DEAD_W-1:0] DEAD_ONE = 1;

    logic [DEAD_W-1:0] dead_q, dead_d;
    logic              pwm_q, pwm_d;
    logic              pwm_n_q, pwm_n_d;
    logic              raw_edge;
    logic              gate_open;

    always_comb begin
        raw_edge = (pwm_raw_d != pwm_raw_q);
        dead_d   = dead_q;
        if (raw_edge) begin
            dead_d = dead_time;
        end else if (dead_q != '0) begin
            dead_d = dead_q - DEAD_ONE;
        end
        // Both outputs stay low until the first sample and while the gap counter runs.
        gate_open = have_prev_d && (dead_d == '0);
        pwm_d     = gate_open && pwm_raw_d;
        pwm_n_d   = gate_open && !pwm_raw_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dead_q  <= '0;
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
            pwm_n_q <= pwm_n_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_n_out = pwm_n_q;
`else
    logic unused_dead_time;
    assign unused_dead_time = ^dead_time;
    assign pwm_out          = pwm_raw_q;
    assign pwm_n_out        = 1'b0;
`endif

endmodule

// File: tb/tb_counter_pwm_compare.sv
// Directed + randomized bench for counter_pwm_compare against a period/duty reference model.
module tb_counter_pwm_compare;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] count_in;
    logic       count_valid;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       pwm_n_out;
    logic [3:0] dead_time;
    logic       match_pulse;
    logic       wrap_pulse;
    logic [7:0] period_cnt;

    counter_pwm_compare #(.WIDTH(8), .DEAD_W(4)) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm_out(pwm_out), .pwm_n_out(pwm_n_out), .dead_time(dead_time),
        .match_pulse(match_pulse), .wrap_pulse(wrap_pulse), .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model: what the period/duty rules say the outputs must be
    logic [7:0] m_active, m_shadow, m_prev, e_period;
    bit         m_pending, m_have, e_raw, e_match, e_wrap;
    int         since;
    int         hi_acc, mt_acc, zc_acc;
    bit         off_v;
    logic [7:0] off_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_shadow = 0; m_prev = 0; e_period = 0;
        m_pending = 0; m_have = 0; e_raw = 0; e_match = 0; e_wrap = 0;
        since = 255;
    endtask

    task automatic check_outs();
        bit eo, en;
`ifdef PWM_DEADTIME_EN
        eo = m_have && (since >= int'(dead_time)) && e_raw;
        en = m_have && (since >= int'(dead_time)) && !e_raw;
        chk("never_both_high", {31'd0, pwm_out & pwm_n_out}, 0);
`else
        eo = e_raw;
        en = 1'b0;
`endif
        chk("pwm_out", {31'd0, pwm_out}, {31'd0, eo});
        chk("pwm_n_out", {31'd0, pwm_n_out}, {31'd0, en});
        chk("match_pulse", {31'd0, match_pulse}, {31'd0, e_match});
        chk("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, e_wrap});
        chk("period_cnt", {24'd0, period_cnt}, {24'd0, e_period});
    endtask

    task automatic step(input bit cv, input logic [7:0] cnt, input bit dv,
                        input logic [7:0] dval, output bit acc);
        bit w, old_raw;
        logic [7:0] eff;
        count_valid = cv; count_in = cnt; duty_valid = dv; duty_in = dval;
        chk("duty_ready", {31'd0, duty_ready}, {31'd0, !m_pending});
        w   = cv && m_have && (cnt < m_prev);
        eff = (w && m_pending) ? m_shadow : m_active;
        acc = dv && !m_pending;
        @(posedge clk); #1;
        old_raw = e_raw;
        if (cv) begin
            e_raw = (cnt < eff); e_match = (cnt == eff); e_wrap = w;
            if (w) e_period = e_period + 8'd1;
            m_prev = cnt; m_have = 1;
        end else begin
            e_match = 0; e_wrap = 0;
        end
        if (w && m_pending) begin
            m_active = m_shadow; m_pending = 0;
        end else if (acc) begin
            m_shadow = dval; m_pending = 1;
        end
        if (e_raw != old_raw) since = 0;
        else if (since < 255) since++;
        check_outs();
        hi_acc += int'(pwm_out);
        mt_acc += int'(match_pulse);
        zc_acc += int'(!pwm_out && !pwm_n_out);
    endtask

    task automatic run(input int lo, input int hi);
        bit a;
        for (int c = lo; c <= hi; c++) begin
            step(1'b1, 8'(c), off_v, off_d, a);
            if (a) off_v = 0;
        end
    endtask

    task automatic offer(input logic [7:0] d);
        off_v = 1; off_d = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        off_v = 0;
        check_outs();
        chk("reset_ready", {31'd0, duty_ready}, 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        logic [7:0] pcnt, rc;
        reset = 1'b0; count_in = 0; count_valid = 0; duty_in = 0; duty_valid = 0;
        dead_time = 0; hi_acc = 0; mt_acc = 0; zc_acc = 0; off_v = 0; off_d = 0;
        #2;
        do_reset();

        // basic PWM with duty 0x40
        offer(8'h40);
        hi_acc = 0;
        run(0, 0);
        chk("t1_ready_drop", {31'd0, duty_ready}, 0);
        run(1, 255);
        chk("t1_first_period_hi", hi_acc, 0);
        hi_acc = 0; mt_acc = 0;
        run(0, 255);
        chk("t1_second_period_hi", hi_acc, 64);
        chk("t1_match_once", mt_acc, 1);
        run(0, 0);
        chk("t1_period_two", {24'd0, period_cnt}, 2);

        // accept on the wrap sample: old duty kept for this period
        run(1, 255);
        offer(8'h10);
        hi_acc = 0;
        run(0, 255);
        chk("t2_old_duty_kept", hi_acc, 64);
        hi_acc = 0;
        run(0, 255);
        chk("t2_new_duty_hi", hi_acc, 16);

        // back-pressure
        run(0, 0);
        offer(8'h20);
        run(1, 1);
        offer(8'h30);
        run(2, 2);
        chk("t3_ready_low", {31'd0, duty_ready}, 0);
        run(3, 255);
        chk("t3_ready_hold", {31'd0, duty_ready}, 0);
        run(0, 0);
        chk("t3_ready_back", {31'd0, duty_ready}, 1);
        run(1, 1);
        chk("t3_second_accepted", {31'd0, duty_ready}, 0);

        // extremes and non-wrap load
        run(2, 255);
        run(0, 0);
        offer(8'h00);
        run(1, 255);
        hi_acc = 0; mt_acc = 0;
        run(0, 255);
        chk("t4_duty0_hi", hi_acc, 0);
        chk("t4_duty0_match", mt_acc, 1);
        offer(8'hFF);
        run(0, 255);
        hi_acc = 0;
        run(0, 255);
        chk("t4_dutyff_hi", hi_acc, 255);
        chk("t4_dutyff_low_at_ff", {31'd0, pwm_out}, 0);
        run(0, 8'h80);
        pcnt = e_period;
        run(5, 5);
        chk("t4_load_wrap", {31'd0, wrap_pulse}, 1);
        chk("t4_load_period", {24'd0, period_cnt}, {24'd0, pcnt + 8'd1});

        // hold then reset mid-period
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'($urandom), 1'b0, 8'h00, a);
            chk("t5_hold_pwm", {31'd0, pwm_out}, 1);
        end
        run(6, 8'h20);
        #2;
        do_reset();
        step(1'b1, 8'h50, 1'b0, 8'h00, a);
        chk("t5_first_no_wrap", {31'd0, wrap_pulse}, 0);

        // randomized counter with enable gaps, loads and a holding producer
        rc = 8'h51;
        for (int i = 0; i < 1500; i++) begin
            bit cv;
            cv = ($urandom_range(0, 9) != 0);
            if (!off_v && $urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0:       offer(8'h00);
                    1:       offer(8'hFF);
                    default: offer(8'($urandom));
                endcase
            end
            step(cv, rc, off_v, off_d, a);
            if (a) off_v = 0;
`ifdef PWM_DEADTIME_EN
            if (m_have) chk("r_complement", {31'd0, pwm_n_out}, {31'd0, !pwm_out});
`endif
            if (cv) rc = ($urandom_range(0, 49) == 0) ? 8'($urandom) : rc + 8'd1;
        end

`ifdef PWM_DEADTIME_EN
        // dead-time gaps with duty 0x40
        #2;
        do_reset();
        offer(8'h40);
        run(0, 255);
        run(0, 8'h80);
        dead_time = 4'd3;
        run(8'h81, 255);
        zc_acc = 0;
        run(0, 255);
        chk("t6_dead_gap_cycles", zc_acc, 6);
        dead_time = 4'd0;
        run(0, 8'h80);
        chk("t6_dt0_complement", {31'd0, pwm_n_out}, {31'd0, !pwm_out});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
